imu_bias_remover: RTL and testbench



---
 rtl/imu_bias_remover.sv | 104 ++++++++++
 tb/tb_imu_bias_remover.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imu_bias_remover.sv
// Averages the first 2**CAL_LOG2 samples into a bias, then emits sample minus bias as signed 32-bit.
// Registered output, one cycle after sample_valid; no backpressure. Optional deadband: IMU_BIAS_DEADBAND_EN.
module imu_bias_remover #(
  parameter int          DATA_W   = 16,
  parameter int          CAL_LOG2 = 8,
  parameter int unsigned DEADBAND = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              recalibrate,
  output logic [31:0]       output_32,
  output logic              output_valid,
  output logic              calibrating,
  output logic [31:0]       bias_32
);

  typedef enum logic {CAL, RUN} state_t;

  state_t               state_q, state_d;
  logic signed [31:0]   acc_q, acc_d;
  logic signed [31:0]   bias_q, bias_d;
  logic signed [31:0]   out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic [CAL_LOG2-1:0]  cnt_q, cnt_d;
  logic signed [31:0]   sample_ext;
  logic signed [31:0]   acc_sum;
  logic signed [31:0]   diff;
  logic signed [31:0]   corrected;

  if (DATA_W + CAL_LOG2 > 31 || DEADBAND > 32'h7FFF_FFFF) begin : g_param_check
    $error("imu_bias_remover: DATA_W+CAL_LOG2 must be <= 31 and DEADBAND must fit in 31 bits");
  end

  assign sample_ext = {{(32-DATA_W){sample_in[DATA_W-1]}}, sample_in};
  assign acc_sum    = acc_q + sample_ext;
  assign diff       = sample_ext - bias_q;

`ifdef IMU_BIAS_DEADBAND_EN
  localparam logic signed [31:0] DB_S = 32'(DEADBAND);
  assign corrected = (diff >= -DB_S && diff <= DB_S) ? 32'sd0 : diff;
`else
  assign corrected = diff;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CAL;
      acc_q     <= '0;
      cnt_q     <= '0;
      bias_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bias_q    <= bias_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bias_d    = bias_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    // Recalibrate wins over a coincident sample; the old bias stays visible until replaced.
    if (recalibrate) begin
      state_d = CAL;
      acc_d   = '0;
      cnt_d   = '0;
      out_d   = '0;
    end else if (sample_valid) begin
      case (state_q)
        CAL: begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            bias_d  = acc_sum >>> CAL_LOG2;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          out_d     = corrected;
          out_vld_d = 1'b1;
        end
        default: state_d = CAL;
      endcase
    end
  end

  assign output_32    = out_q;
  assign output_valid = out_vld_q;
  assign calibrating  = (state_q == CAL);
  assign bias_32      = bias_q;

endmodule

// File: tb/tb_imu_bias_remover.sv
// Directed bench for imu_bias_remover with CAL_LOG2=2; expected outputs are queued when samples are driven.
module tb_imu_bias_remover;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        recalibrate;
  logic [31:0] output_32;
  logic        output_valid;
  logic        calibrating;
  logic [31:0] bias_32;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int m_bias   = 0;
  int m_last   = 0;
  bit m_cal    = 1'b1;

  imu_bias_remover #(.DATA_W(16), .CAL_LOG2(2), .DEADBAND(4)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .recalibrate(recalibrate), .output_32(output_32), .output_valid(output_valid),
    .calibrating(calibrating), .bias_32(bias_32)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_of(input int v);
    int d;
    d = v - m_bias;
`ifdef IMU_BIAS_DEADBAND_EN
    if (d >= -4 && d <= 4) d = 0;
`endif
    return d;
  endfunction

  // One output is due per cycle after each RUN-state sample; otherwise output must hold and valid stay low.
  task automatic check_cycle();
    if (exp_q.size() > 0) begin
      int e;
      e = exp_q.pop_front();
      chk("out_valid", {31'd0, output_valid}, 32'd1);
      chk("out_32", output_32, e);
      m_last = e;
    end else begin
      chk("out_valid_idle", {31'd0, output_valid}, 32'd0);
      chk("out_32_hold", output_32, m_last);
    end
  endtask

  task automatic send(input int v, input int gap);
    sample_valid = 1'b1;
    sample_in    = v[15:0];
    if (!m_cal) exp_q.push_back(exp_of(v));
    tick();
    sample_valid = 1'b0;
    check_cycle();
    for (int i = 0; i < gap; i++) begin
      tick();
      check_cycle();
    end
  endtask

  task automatic pulse_recal();
    recalibrate = 1'b1;
    tick();
    recalibrate = 1'b0;
    m_cal  = 1'b1;
    m_last = 0;
    check_cycle();
    chk("recal_calibrating", {31'd0, calibrating}, 32'd1);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    recalibrate  = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    m_cal  = 1'b1;
    m_bias = 0;
    m_last = 0;
    chk("rst_out_32", output_32, 32'd0);
    chk("rst_out_valid", {31'd0, output_valid}, 32'd0);
    chk("rst_calibrating", {31'd0, calibrating}, 32'd1);
    chk("rst_bias_32", bias_32, 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    recalibrate  = 1'b0;
    tick();
    do_reset();

    // Calibration 10,12,9,13 with irregular gaps -> bias 11.
    send(10, 2);
    send(12, 0);
    send(9, 3);
    chk("cal_still_on", {31'd0, calibrating}, 32'd1);
    send(13, 0);
    chk("cal_done", {31'd0, calibrating}, 32'd0);
    chk("bias_11", bias_32, 32'd11);
    m_cal  = 1'b0;
    m_bias = 11;

    // Run: 20 -> 9, min input -> 0xFFFF7FF5, then back-to-back samples.
    send(20, 1);
    chk("plan_out_9", output_32, 32'd9);
    send(-32768, 1);
    chk("plan_out_min", output_32, 32'hFFFF7FF5);
    send(5, 0);
    send(-7, 0);
    send(32767, 1);

    // Deadband edges around bias 11.
    send(13, 1);
`ifdef IMU_BIAS_DEADBAND_EN
    chk("deadband_13", output_32, 32'd0);
`else
    chk("nodeadband_13", output_32, 32'd2);
`endif
    send(15, 0);
    send(16, 0);
    send(7, 0);
    send(6, 1);

    // Recalibrate coincident with a sample: sample dropped, bias kept.
    sample_valid = 1'b1;
    sample_in    = 16'd100;
    pulse_recal();
    sample_valid = 1'b0;
    chk("recal_bias_kept", bias_32, 32'd11);
    chk("recal_out_zero", output_32, 32'd0);
    send(0, 0);
    send(0, 1);
    send(0, 0);
    chk("recal_bias_still_11", bias_32, 32'd11);
    send(0, 0);
    chk("bias_0", bias_32, 32'd0);
    m_cal  = 1'b0;
    m_bias = 0;
    send(-9, 1);

    // Recalibrate mid-calibration restarts the count; then negative floor bias.
    pulse_recal();
    send(50, 0);
    send(50, 1);
    pulse_recal();
    send(-3, 0);
    send(-4, 2);
    send(-4, 0);
    chk("restart_count", {31'd0, calibrating}, 32'd1);
    send(-4, 0);
    chk("bias_neg_floor", bias_32, 32'hFFFFFFFC);
    m_cal  = 1'b0;
    m_bias = -4;
    send(0, 0);
    send(-100, 1);

    // Reset from RUN, then reset after 2 of 4 calibration samples.
    do_reset();
    send(100, 0);
    send(100, 1);
    do_reset();
    send(8, 0);
    send(8, 1);
    send(8, 0);
    chk("post_rst_cal", {31'd0, calibrating}, 32'd1);
    send(8, 0);
    chk("bias_8", bias_32, 32'd8);
    m_cal  = 1'b0;
    m_bias = 8;
    send(8, 0);
    send(20, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
